result_evaluator: RTL and testbench

Post-inference evaluation stage for the MLP accelerator. After the feedforward pass has filled the output-neuron buffer, this block scans that buffer and the label buffer and finds the argmax of each. It flags whether the prediction is correct and keeps running sample and correct counters for the host to read through GPIO. It runs in the controller's schedule between feedforward completion and the next load/backprop step, and reads both buffers through their read ports.

---
 rtl/result_evaluator.sv | 128 ++++++++++++
 tb/tb_result_evaluator.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_evaluator.sv
// Post-inference evaluator: scans the output-neuron and label buffers, finds the argmax of
// each, flags whether the prediction is correct and keeps saturating sample/correct counters.
//
// state   | meaning
// IDLE    | waiting for run; read address holds
// SCAN    | issuing read addresses 0..N_OUT-1, folding in data returned for the previous one
// DRAIN   | folding in the last word, registering results and updating counters
// DONE    | one-cycle fin pulse
module result_evaluator #(
    parameter int N_OUT      = 10,
    parameter int ADDR_WIDTH = 8,
    parameter int W_NEURON   = 16,
    parameter int W_DATA     = 8,
    parameter int W_CLASS    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  clear_stats,
    output logic [ADDR_WIDTH-1:0] out_ra,
    input  logic [W_NEURON-1:0]   out_q,
    output logic [ADDR_WIDTH-1:0] t_ra,
    input  logic [W_DATA-1:0]     t_q,
    output logic                  busy,
    output logic                  fin,
    output logic [W_CLASS-1:0]    pred_class,
    output logic [W_CLASS-1:0]    label_class,
    output logic                  correct,
    output logic [15:0]           sample_count,
    output logic [15:0]           correct_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_OUT - 1);

    logic [1:0]                  state;
    logic signed [W_NEURON-1:0]  best_out, nxt_best_out;
    logic [W_DATA-1:0]           best_t, nxt_best_t;
    logic [W_CLASS-1:0]          best_out_idx, nxt_best_out_idx;
    logic [W_CLASS-1:0]          best_t_idx, nxt_best_t_idx;
    logic [ADDR_WIDTH-1:0]       cmp_addr;
    logic [W_CLASS-1:0]          cmp_idx;
    logic                        do_cmp;
    logic                        nxt_correct;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Read data lags the address by one cycle, so the word being folded in belongs to out_ra-1.
    always_comb begin
        cmp_addr         = (state == S_DRAIN) ? LAST_ADDR : out_ra - ADDR_WIDTH'(1);
        cmp_idx          = W_CLASS'(cmp_addr);
        do_cmp           = (state == S_DRAIN) || ((state == S_SCAN) && (out_ra != '0));
        nxt_best_out     = best_out;
        nxt_best_out_idx = best_out_idx;
        nxt_best_t       = best_t;
        nxt_best_t_idx   = best_t_idx;
        if (do_cmp) begin
            if ((cmp_addr == '0) || ($signed(out_q) > best_out)) begin
                nxt_best_out     = $signed(out_q);
                nxt_best_out_idx = cmp_idx;
            end
            if ((cmp_addr == '0) || (t_q > best_t)) begin
                nxt_best_t     = t_q;
                nxt_best_t_idx = cmp_idx;
            end
        end
        nxt_correct = (nxt_best_out_idx == nxt_best_t_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            out_ra        <= '0;
            best_out      <= '0;
            best_out_idx  <= '0;
            best_t        <= '0;
            best_t_idx    <= '0;
            pred_class    <= '0;
            label_class   <= '0;
            correct       <= 1'b0;
            sample_count  <= '0;
            correct_count <= '0;
        end else begin
            best_out     <= nxt_best_out;
            best_out_idx <= nxt_best_out_idx;
            best_t       <= nxt_best_t;
            best_t_idx   <= nxt_best_t_idx;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state  <= S_SCAN;
                        out_ra <= '0;
                    end
                end
                S_SCAN: begin
                    if (out_ra == LAST_ADDR) state <= S_DRAIN;
                    else                     out_ra <= out_ra + ADDR_WIDTH'(1);
                end
                S_DRAIN: begin
                    pred_class  <= nxt_best_out_idx;
                    label_class <= nxt_best_t_idx;
                    correct     <= nxt_correct;
                    state       <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
            // Clear has priority over a coincident DRAIN update.
            if (clear_stats) begin
                sample_count  <= '0;
                correct_count <= '0;
            end else if (state == S_DRAIN) begin
                sample_count <= sat_inc(sample_count);
                if (nxt_correct) correct_count <= sat_inc(correct_count);
            end
        end
    end

    assign t_ra = out_ra;
    assign busy = (state != S_IDLE);
    assign fin  = (state == S_DONE);

endmodule

// File: tb/tb_result_evaluator.sv
// Scoreboard bench for result_evaluator: buffers are filled, expected results computed by a
// plain argmax reference and queued; a monitor compares them whenever fin is presented.
module tb_result_evaluator;
    localparam int N_OUT = 10;

    logic        clk = 1'b0;
    logic        reset, run, clear_stats;
    logic [7:0]  out_ra, t_ra, pred_class, label_class;
    logic [15:0] out_q, sample_count, correct_count;
    logic [7:0]  t_q;
    logic        busy, fin, correct;

    logic [15:0] out_mem[256];
    logic [7:0]  t_mem[256];

    typedef struct {
        int pred;
        int label;
        int corr;
        int sc;
        int cc;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int model_sc = 0;
    int model_cc = 0;

    always #5 clk = ~clk;

    result_evaluator dut (
        .clk(clk), .reset(reset), .run(run), .clear_stats(clear_stats),
        .out_ra(out_ra), .out_q(out_q), .t_ra(t_ra), .t_q(t_q),
        .busy(busy), .fin(fin), .pred_class(pred_class), .label_class(label_class),
        .correct(correct), .sample_count(sample_count), .correct_count(correct_count)
    );

    // Synchronous-read buffers: data valid one cycle after the address.
    always @(posedge clk) begin
        out_q <= out_mem[out_ra];
        t_q   <= t_mem[t_ra];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fin) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fin", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pred_class", int'(pred_class), e.pred);
                chk("label_class", int'(label_class), e.label);
                chk("correct", int'(correct), e.corr);
                chk("sample_count", int'(sample_count), e.sc);
                chk("correct_count", int'(correct_count), e.cc);
            end
        end
    end

    function automatic int argmax_signed();
        int best = 0;
        for (int i = 1; i < N_OUT; i++)
            if ($signed(out_mem[i]) > $signed(out_mem[best])) best = i;
        return best;
    endfunction

    function automatic int argmax_unsigned();
        int best = 0;
        for (int i = 1; i < N_OUT; i++)
            if (t_mem[i] > t_mem[best]) best = i;
        return best;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_fin"}, int'(fin), 0);
        chk({tag, "_correct"}, int'(correct), 0);
        chk({tag, "_pred"}, int'(pred_class), 0);
        chk({tag, "_label"}, int'(label_class), 0);
        chk({tag, "_sc"}, int'(sample_count), 0);
        chk({tag, "_cc"}, int'(correct_count), 0);
        chk({tag, "_out_ra"}, int'(out_ra), 0);
        chk({tag, "_t_ra"}, int'(t_ra), 0);
    endtask

    // mode 0 normal, 1 run pulsed mid-scan, 2 clear_stats on the DRAIN edge, 3 reset at cycle 5
    task automatic run_sample(input int mode);
        exp_t e;
        bit   got = 0;
        e.pred  = argmax_signed();
        e.label = argmax_unsigned();
        e.corr  = (e.pred == e.label) ? 1 : 0;
        if (mode == 2) begin
            model_sc = 0;
            model_cc = 0;
        end else if (mode != 3) begin
            if (model_sc < 65535) model_sc++;
            if (e.corr == 1 && model_cc < 65535) model_cc++;
        end
        e.sc = model_sc;
        e.cc = model_cc;
        if (mode != 3) exp_q.push_back(e);

        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
        for (int k = 1; k <= N_OUT + 6; k++) begin
            @(negedge clk);
            if (k <= N_OUT) begin
                chk("scan_out_ra", int'(out_ra), k - 1);
                chk("scan_t_ra", int'(t_ra), k - 1);
            end
            if (k == N_OUT + 1) chk("drain_busy", int'(busy), 1);
            if (k == N_OUT + 3) begin
                chk("post_fin_low", int'(fin), 0);
                chk("post_busy_low", int'(busy), 0);
                chk("addr_hold", int'(out_ra), N_OUT - 1);
            end
            if (fin && !got) begin
                got = 1;
                chk("fin_latency", k, N_OUT + 2);
            end
            if (mode == 1 && k == 4) run = 1'b1;
            if (mode == 1 && k == 5) run = 1'b0;
            if (mode == 2 && k == N_OUT + 1) clear_stats = 1'b1;
            if (mode == 2 && k == N_OUT + 2) clear_stats = 1'b0;
            if (mode == 3 && k == 5) begin
                reset = 1'b1;
                @(negedge clk);
                check_reset_state("abort");
                reset = 1'b0;
                model_sc = 0;
                model_cc = 0;
                break;
            end
        end
        if (mode != 3 && !got) chk("fin_timeout", 0, 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_const(input logic [15:0] ov, input logic [7:0] tv);
        for (int i = 0; i < 256; i++) begin
            out_mem[i] = ov;
            t_mem[i]   = tv;
        end
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; clear_stats = 1'b0;
        fill_const(16'h0000, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        #1 reset = 1'b0;

        // basic match
        fill_const(-16'sd100, 8'd0);
        out_mem[3] = 16'sd500; t_mem[3] = 8'd1;
        run_sample(0);

        // mismatch with signed compare
        fill_const(-16'sd300, 8'd0);
        out_mem[0] = -16'sd1; out_mem[7] = -16'sd2; t_mem[7] = 8'd1;
        run_sample(0);

        // ties resolve to lowest index
        fill_const(16'h0000, 8'd0);
        out_mem[2] = 16'h7FFF; out_mem[5] = 16'h7FFF; out_mem[9] = 16'h7FFF;
        t_mem[4] = 8'hFF; t_mem[6] = 8'hFF;
        run_sample(0);

        // randomized samples, some with narrow ranges to provoke ties
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < N_OUT; i++) begin
                out_mem[i] = (n % 3 == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
                t_mem[i]   = (n % 2 == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom);
            end
            if (n % 4 == 1) t_mem[argmax_signed()] = 8'hFF;
            run_sample(0);
        end

        // run during scan is ignored
        run_sample(1);

        // clear_stats in idle
        @(posedge clk); #1 clear_stats = 1'b1;
        @(posedge clk); #1 clear_stats = 1'b0;
        model_sc = 0; model_cc = 0;
        @(negedge clk);
        chk("idle_clear_sc", int'(sample_count), 0);
        chk("idle_clear_cc", int'(correct_count), 0);

        fill_const(-16'sd100, 8'd0);
        out_mem[6] = 16'sd1; t_mem[6] = 8'd9;
        run_sample(0);
        run_sample(2);
        chk("clear_hold_sc", int'(sample_count), 0);

        // reset mid-scan
        run_sample(0);
        run_sample(3);
        repeat (N_OUT + 4) @(negedge clk);
        chk("abort_no_count", int'(sample_count), 0);

        // saturation: preload counters just below full scale
        @(posedge clk); #1;
        force dut.sample_count = 16'hFFFE;
        force dut.correct_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.sample_count;
        release dut.correct_count;
        model_sc = 65534; model_cc = 65534;
        fill_const(-16'sd100, 8'd0);
        out_mem[8] = 16'sd50; t_mem[8] = 8'd200;
        run_sample(0);
        run_sample(0);

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1, "timeout");
    end
endmodule
